// File: rtl/gpio_periph_pkg.sv
// gpio_periph_pkg
// Purpose: shared definitions for the memory-mapped GPIO peripheral.
//   - Byte offsets of every register in the 4 KB GPIO window.
//   - An enum naming the register selected by an access.
//   - A helper that decodes a bus address into that enum.
// Ports: none (package).
package gpio_periph_pkg;

  localparam int unsigned ADDR_W = 12;

  localparam logic [ADDR_W-1:0] GPIO_DO  = 12'h000;
  localparam logic [ADDR_W-1:0] GPIO_OE  = 12'h004;
  localparam logic [ADDR_W-1:0] GPIO_DI  = 12'h008;
  localparam logic [ADDR_W-1:0] GPIO_SET = 12'h00C;
  localparam logic [ADDR_W-1:0] GPIO_CLR = 12'h010;

  typedef enum logic [2:0] {
    REG_DO,
    REG_OE,
    REG_DI,
    REG_SET,
    REG_CLR,
    REG_NONE
  } regSelE;

  // Byte lanes are not addressable, so the two low address bits are masked
  // off before matching against the word-aligned register offsets.
  function automatic regSelE decodeReg(input logic [ADDR_W-1:0] addr);
    regSelE sel;
    case (addr & 12'hFFC)
      GPIO_DO:  sel = REG_DO;
      GPIO_OE:  sel = REG_OE;
      GPIO_DI:  sel = REG_DI;
      GPIO_SET: sel = REG_SET;
      GPIO_CLR: sel = REG_CLR;
      default:  sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync
// Purpose: WIDTH-wide two-flop synchronizer bringing asynchronous pin inputs
//   into the clk domain. Each bit is synchronized independently, so a
//   multi-bit change may be seen over two consecutive cycles.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset, clears both flop stages
//   d_i    - asynchronous input bits
//   q_o    - synchronized bits, two clocks of latency
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; only the second stage is used downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_periph.sv
// gpio_periph
// Purpose: memory-mapped GPIO peripheral on the CPU native valid/ready bus.
//   Provides per-pin output data and output enable registers, a synchronized
//   view of the input pins, and atomic set/clear of the output data register.
//   Every selected request is acknowledged with a one-cycle mem_ready pulse
//   one clock after it is accepted.
// Ports:
//   clk        - clock, rising edge
//   reset_     - asynchronous active-high reset
//   mem_sel    - SoC address decode hit for this peripheral
//   mem_valid  - CPU request valid, held until mem_ready
//   mem_ready  - access complete, one-cycle pulse
//   mem_wr     - 1 = write, 0 = read (full-word accesses only)
//   mem_addr   - byte offset inside the 4 KB window
//   mem_wdata  - write data
//   mem_rdata  - read data, valid while mem_ready is high
//   gpio_oe    - per-pin output enable (1 = drive)
//   gpio_do    - per-pin output value
//   gpio_di    - per-pin input, asynchronous to clk
module gpio_periph
  import gpio_periph_pkg::*;
#(
  parameter int NR_GPIOS = 8
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                mem_sel,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic                mem_wr,
  input  logic [11:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic [31:0]         mem_rdata,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic [NR_GPIOS-1:0] gpio_do,
  input  logic [NR_GPIOS-1:0] gpio_di
);

  logic [NR_GPIOS-1:0] dataOut_q, dataOut_d;
  logic [NR_GPIOS-1:0] oe_q, oe_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;

  logic                accept;
  regSelE              regSel;
  logic [NR_GPIOS-1:0] wrBits;
  logic [NR_GPIOS-1:0] diSync;
  logic                unusedWdata;

  gpio_sync #(
    .WIDTH (NR_GPIOS)
  ) uSync (
    .clk_i (clk),
    .rst_i (reset_),
    .d_i   (gpio_di),
    .q_o   (diSync)
  );

  // Write data bits above the pin count have no storage behind them.
  assign unusedWdata = ^mem_wdata;

  // Accept only while no acknowledge is outstanding; the CPU keeps
  // mem_valid high during the ready cycle, and that must not be taken as a
  // second request.
  always_comb begin
    accept    = mem_valid & mem_sel & ~ready_q;
    regSel    = decodeReg(mem_addr);
    wrBits    = mem_wdata[NR_GPIOS-1:0];
    ready_d   = accept;
    dataOut_d = dataOut_q;
    oe_d      = oe_q;
    rdata_d   = rdata_q;

    if (accept) begin
      rdata_d = '0;
      if (mem_wr) begin
        case (regSel)
          REG_DO:  dataOut_d = wrBits;
          REG_OE:  oe_d      = wrBits;
          REG_SET: dataOut_d = dataOut_q | wrBits;
          REG_CLR: dataOut_d = dataOut_q & ~wrBits;
          default: ;
        endcase
      end else begin
        case (regSel)
          REG_DO:  rdata_d[NR_GPIOS-1:0] = dataOut_q;
          REG_OE:  rdata_d[NR_GPIOS-1:0] = oe_q;
          REG_DI:  rdata_d[NR_GPIOS-1:0] = diSync;
          default: ;
        endcase
      end
    end
  end

  // All bus-visible state lives here; reset abandons any request in flight
  // because nothing is committed until the accept edge.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      dataOut_q <= '0;
      oe_q      <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      dataOut_q <= dataOut_d;
      oe_q      <= oe_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
    end
  end

  assign gpio_do   = dataOut_q;
  assign gpio_oe   = oe_q;
  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_periph.sv
// tb_gpio_periph
// Purpose: self-checking bench for gpio_periph. Directed steps cover reset,
//   the register map, set/clear, input synchronization latency, unselected
//   requests and held-valid back-to-back access; a randomized phase then
//   compares the DUT against a register-level reference model.
// Ports: none (top-level bench).
module tb_gpio_periph;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset_;
  logic          mem_sel;
  logic          mem_valid;
  logic          mem_ready;
  logic          mem_wr;
  logic [11:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [N-1:0]  gpio_oe;
  logic [N-1:0]  gpio_do;
  logic [N-1:0]  gpio_di;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] doModel;
  logic [N-1:0] oeModel;
  logic [N-1:0] diModel;

  always #5 clk = ~clk;

  gpio_periph #(
    .NR_GPIOS (N)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .mem_sel   (mem_sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .gpio_oe   (gpio_oe),
    .gpio_do   (gpio_do),
    .gpio_di   (gpio_di)
  );

  // One comparison: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference model: register file as the programmer sees it.
  function automatic logic [31:0] modelRead(input logic [11:0] addr);
    case (addr[11:2])
      10'd0:   return 32'(doModel);
      10'd1:   return 32'(oeModel);
      10'd2:   return 32'(diModel);
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelWrite(input logic [11:0] addr, input logic [31:0] wdata);
    case (addr[11:2])
      10'd0:   doModel = wdata[N-1:0];
      10'd1:   oeModel = wdata[N-1:0];
      10'd3:   doModel = doModel | wdata[N-1:0];
      10'd4:   doModel = doModel & ~wdata[N-1:0];
      default: ;
    endcase
  endtask

  // One isolated bus access; the caller has already updated the model, so
  // the pins must match it on the cycle ready rises.
  task automatic applyStimulus(input logic wr, input logic [11:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    int cyc;
    @(negedge clk);
    checkOutput("readyIdle", 32'(mem_ready), 32'h0);
    mem_valid = 1'b1;
    mem_sel   = 1'b1;
    mem_wr    = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!mem_ready && cyc < 4);
    checkOutput("latency", 32'(cyc), 32'd1);
    checkOutput("pinsDo", 32'(gpio_do), 32'(doModel));
    checkOutput("pinsOe", 32'(gpio_oe), 32'(oeModel));
    rdata     = mem_rdata;
    mem_valid = 1'b0;
    mem_wr    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("readyPulse", 32'(mem_ready), 32'h0);
  endtask

  task automatic doWrite(input logic [11:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    modelWrite(addr, wdata);
    applyStimulus(1'b1, addr, wdata, dummy);
  endtask

  task automatic doRead(input string tag, input logic [11:0] addr);
    logic [31:0] r;
    logic [31:0] exp;
    exp = modelRead(addr);
    applyStimulus(1'b0, addr, 32'h0, r);
    checkOutput(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic [9:0]  word;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          op;

    reset_    = 1'b1;
    mem_sel   = 1'b0;
    mem_valid = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 12'h0;
    mem_wdata = 32'h0;
    gpio_di   = '0;
    doModel   = '0;
    oeModel   = '0;
    diModel   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    checkOutput("resetDo", 32'(gpio_do), 32'h0);
    checkOutput("resetOe", 32'(gpio_oe), 32'h0);
    checkOutput("resetReady", 32'(mem_ready), 32'h0);
    checkOutput("resetRdata", mem_rdata, 32'h0);

    $display("[TB] directed register map");
    doWrite(12'h000, 32'h0000_00A5);
    checkOutput("doA5", 32'(gpio_do), 32'h0000_00A5);
    doWrite(12'h004, 32'h0000_000F);
    checkOutput("oe0F", 32'(gpio_oe), 32'h0000_000F);
    doWrite(12'h00C, 32'h0000_0002);
    checkOutput("setA7", 32'(gpio_do), 32'h0000_00A7);
    doWrite(12'h010, 32'h0000_0080);
    checkOutput("clr27", 32'(gpio_do), 32'h0000_0027);
    doRead("readDo", 12'h000);
    checkOutput("readDoConst", mem_rdata, 32'h0000_0027);

    $display("[TB] input synchronizer");
    gpio_di = 8'h3C;
    applyStimulus(1'b0, 12'h008, 32'h0, r);
    checkOutput("diEarly1", r, 32'h0);
    applyStimulus(1'b0, 12'h008, 32'h0, r);
    checkOutput("diSynced", r, 32'h0000_003C);
    diModel = 8'h3C;
    doWrite(12'h008, 32'h0000_00FF);
    doRead("diAfterWrite", 12'h008);
    doRead("readOe", 12'h004);
    checkOutput("readOeConst", mem_rdata, 32'h0000_000F);
    doRead("readHole", 12'h100);
    doRead("readSetReg", 12'h00C);

    $display("[TB] unselected request");
    @(negedge clk);
    mem_valid = 1'b1;
    mem_sel   = 1'b0;
    mem_wr    = 1'b1;
    mem_addr  = 12'h000;
    mem_wdata = 32'h0000_00FF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("noSelReady", 32'(mem_ready), 32'h0);
    end
    checkOutput("noSelDo", 32'(gpio_do), 32'h0000_0027);
    mem_valid = 1'b0;
    mem_wr    = 1'b0;

    $display("[TB] held valid back-to-back");
    @(negedge clk);
    mem_valid = 1'b1;
    mem_sel   = 1'b1;
    mem_wr    = 1'b1;
    mem_addr  = 12'h000;
    mem_wdata = 32'h0000_0011;
    @(posedge clk);
    #1;
    checkOutput("b2bReady1", 32'(mem_ready), 32'h1);
    checkOutput("b2bDo1", 32'(gpio_do), 32'h0000_0011);
    mem_wdata = 32'h0000_0022;
    @(posedge clk);
    #1;
    checkOutput("b2bReady2", 32'(mem_ready), 32'h0);
    checkOutput("b2bDo2", 32'(gpio_do), 32'h0000_0011);
    @(posedge clk);
    #1;
    checkOutput("b2bReady3", 32'(mem_ready), 32'h1);
    checkOutput("b2bDo3", 32'(gpio_do), 32'h0000_0022);
    mem_valid = 1'b0;
    mem_wr    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2bReady4", 32'(mem_ready), 32'h0);
    doModel = 8'h22;

    $display("[TB] randomized accesses");
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 9));
      case ($urandom_range(0, 5))
        0:       word = 10'd0;
        1:       word = 10'd1;
        2:       word = 10'd2;
        3:       word = 10'd3;
        4:       word = 10'd4;
        default: word = 10'($urandom_range(5, 1023));
      endcase
      addr  = {word, 2'($urandom)};
      wdata = $urandom;
      if (op == 0) begin
        gpio_di = N'($urandom);
        repeat (2) @(posedge clk);
        #1;
        diModel = gpio_di;
      end else if (op < 5) begin
        doWrite(addr, wdata);
      end else begin
        doRead("randRead", addr);
      end
    end

    $display("[TB] reset during access");
    doWrite(12'h000, 32'hFFFF_FFFF);
    doWrite(12'h004, 32'h0000_00FF);
    doRead("preResetRead", 12'h000);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_sel   = 1'b1;
    mem_wr    = 1'b1;
    mem_addr  = 12'h00C;
    mem_wdata = 32'h0000_005A;
    #2;
    reset_ = 1'b1;
    #1;
    checkOutput("asyncResetDo", 32'(gpio_do), 32'h0);
    checkOutput("asyncResetOe", 32'(gpio_oe), 32'h0);
    checkOutput("asyncResetReady", 32'(mem_ready), 32'h0);
    checkOutput("asyncResetRdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("heldResetReady", 32'(mem_ready), 32'h0);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wr    = 1'b0;
    reset_    = 1'b0;
    doModel   = '0;
    oeModel   = '0;
    @(posedge clk);
    #1;
    checkOutput("droppedDo", 32'(gpio_do), 32'h0);
    checkOutput("droppedReady", 32'(mem_ready), 32'h0);
    doWrite(12'h004, 32'h0000_0003);
    doRead("recoverOe", 12'h004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
